// File: rtl/alu_operand_collector.sv
// Registered ALU operand collector: scalar slots are captured at issue, VGPR slots
// are filled by out-of-order return beats, and the full set is handed over with valid/ready.
module alu_operand_collector #(
    parameter int NUM_LANES = 64,
    parameter int LANE_W    = 32,
    parameter int NUM_SRC   = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               issue_valid,
    output logic                               issue_ready,
    input  logic [4*NUM_SRC-1:0]               issue_sel,
    input  logic [10*NUM_SRC-1:0]              issue_src_constant,
    input  logic [31:0]                        issue_literal,
    input  logic [32*NUM_SRC-1:0]              sgpr_rd_data,
    input  logic [63:0]                        exec_rd_exec_value,
    input  logic [63:0]                        exec_rd_vcc_value,
    input  logic [31:0]                        exec_rd_m0_value,
    input  logic                               exec_rd_scc_value,
    input  logic                               vgpr_rd_valid,
    input  logic [1:0]                         vgpr_rd_idx,
    input  logic [LANE_W*NUM_LANES-1:0]        vgpr_rd_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_SRC*LANE_W*NUM_LANES-1:0] out_data,
    output logic                               out_err
);
    localparam int SLOT_W = LANE_W * NUM_LANES;
    localparam logic [3:0] SEL_VGPR = 4'b0010;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_SRC-1:0]  r_pending;
    logic [SLOT_W-1:0]   r_slot [NUM_SRC];
    logic                r_err;

    logic                w_accept;
    logic                w_illegal;
    logic                w_stray;
    logic [NUM_SRC-1:0]  w_new_pending;
    logic [NUM_SRC-1:0]  w_hit;
    logic [LANE_W-1:0]   w_scalar [NUM_SRC];

    // Per-lane scalar value for one slot; VGPR and illegal codes yield zero.
    function automatic logic [LANE_W-1:0] scalar_val(
        input logic [3:0]  sel,
        input logic [9:0]  cnst,
        input logic [31:0] sgpr,
        input logic [31:0] lit,
        input logic [63:0] vcc,
        input logic [63:0] exec,
        input logic [31:0] m0,
        input logic        scc
    );
        logic [LANE_W-1:0] v;
        v = '0;
        case (sel)
            4'b0000: v = LANE_W'(lit);
            4'b0001: v = LANE_W'($signed(cnst));
            4'b0011: v = LANE_W'(sgpr);
            4'b0100: v = LANE_W'(vcc[31:0]);
            4'b0101: v = LANE_W'(vcc[63:32]);
            4'b0110: v = LANE_W'(m0);
            4'b0111: v = LANE_W'(exec[31:0]);
            4'b1000: v = LANE_W'(exec[63:32]);
            4'b1001: v = LANE_W'(vcc == 64'd0);
            4'b1010: v = LANE_W'(exec == 64'd0);
            4'b1011: v = LANE_W'(scc);
            default: v = '0;
        endcase
        return v;
    endfunction

    assign w_accept = issue_valid && issue_ready;

    always_comb begin
        w_illegal     = 1'b0;
        w_new_pending = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_scalar[i] = scalar_val(issue_sel[4*i +: 4], issue_src_constant[10*i +: 10],
                                     sgpr_rd_data[32*i +: 32], issue_literal,
                                     exec_rd_vcc_value, exec_rd_exec_value,
                                     exec_rd_m0_value, exec_rd_scc_value);
            w_new_pending[i] = (issue_sel[4*i +: 4] == SEL_VGPR);
            if (issue_sel[4*i+3 -: 2] == 2'b11) w_illegal = 1'b1;
        end
    end

    // A beat only lands when collecting and its slot is still outstanding.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_hit[i] = vgpr_rd_valid && (r_state == S_COLLECT) && r_pending[i]
                       && (vgpr_rd_idx == 2'(i));
        end
    end

    assign w_stray = vgpr_rd_valid && (w_hit == '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = (w_new_pending == '0) ? S_DONE : S_COLLECT;
            S_COLLECT: if ((r_pending & ~w_hit) == '0) w_state_nxt = S_DONE;
            S_DONE:    if (out_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        issue_ready = (r_state == S_IDLE);
        out_valid   = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) r_slot[i] <= '0;
        end else begin
            if (w_accept) begin
                r_pending <= w_new_pending;
                for (int i = 0; i < NUM_SRC; i++) r_slot[i] <= {NUM_LANES{w_scalar[i]}};
            end else begin
                r_pending <= r_pending & ~w_hit;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (w_hit[i]) r_slot[i] <= vgpr_rd_data;
                end
            end
            if ((w_accept && w_illegal) || w_stray) r_err <= 1'b1;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_SRC; i++) out_data[i*SLOT_W +: SLOT_W] = r_slot[i];
    end

    assign out_err = r_err;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector: scalar capture, out-of-order VGPR fill,
// backpressure, flag sources, illegal/stray handling and reset during collection.
module tb_alu_operand_collector;
    localparam int NL = 64;
    localparam int LW = 32;
    localparam int NS = 3;
    localparam int SW = NL * LW;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic              issue_ready;
    logic [4*NS-1:0]   issue_sel;
    logic [10*NS-1:0]  issue_src_constant;
    logic [31:0]       issue_literal;
    logic [32*NS-1:0]  sgpr_rd_data;
    logic [63:0]       exec_v;
    logic [63:0]       vcc_v;
    logic [31:0]       m0_v;
    logic              scc_v;
    logic              vgpr_rd_valid;
    logic [1:0]        vgpr_rd_idx;
    logic [SW-1:0]     vgpr_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [NS*SW-1:0]  out_data;
    logic              out_err;

    int total = 0;
    int bad   = 0;

    logic [SW-1:0] vd0;
    logic [SW-1:0] vd2;
    logic [SW-1:0] vjunk;

    alu_operand_collector #(.NUM_LANES(NL), .LANE_W(LW), .NUM_SRC(NS)) dut (
        .clk                (clk),
        .rst                (rst),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .issue_sel          (issue_sel),
        .issue_src_constant (issue_src_constant),
        .issue_literal      (issue_literal),
        .sgpr_rd_data       (sgpr_rd_data),
        .exec_rd_exec_value (exec_v),
        .exec_rd_vcc_value  (vcc_v),
        .exec_rd_m0_value   (m0_v),
        .exec_rd_scc_value  (scc_v),
        .vgpr_rd_valid      (vgpr_rd_valid),
        .vgpr_rd_idx        (vgpr_rd_idx),
        .vgpr_rd_data       (vgpr_rd_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_err            (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] slot(input int i);
        return out_data[i*SW +: SW];
    endfunction

    function automatic logic [SW-1:0] bc(input logic [31:0] v);
        return {NL{v}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [11:0] sel, input logic [29:0] cnst,
                             input logic [95:0] sgpr, input logic [31:0] lit);
        issue_sel          = sel;
        issue_src_constant = cnst;
        sgpr_rd_data       = sgpr;
        issue_literal      = lit;
        issue_valid        = 1'b1;
        step();
        issue_valid        = 1'b0;
    endtask

    task automatic beat(input logic [1:0] idx, input logic [SW-1:0] d);
        vgpr_rd_valid = 1'b1;
        vgpr_rd_idx   = idx;
        vgpr_rd_data  = d;
        step();
        vgpr_rd_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got %b want 1", issue_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got %b want 0", out_err); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got lane0=%h want 0", out_data[31:0]); end
    endtask

    task automatic test_scalar();
        do_accept(12'h013, {10'h0, 10'h3FF, 10'h0}, {32'h0, 32'h0, 32'h0000_1234}, 32'hDEAD_BEEF);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL scalar_out_valid got %b want 1", out_valid); end
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL scalar_issue_ready got %b want 0", issue_ready); end
        total++; if (slot(0) !== bc(32'h0000_1234)) begin bad++; $display("FAIL scalar_slot0 got lane0=%h lane63=%h want 00001234", slot(0)[31:0], slot(0)[SW-1 -: 32]); end
        total++; if (slot(1) !== bc(32'hFFFF_FFFF)) begin bad++; $display("FAIL scalar_slot1 got lane0=%h lane63=%h want ffffffff", slot(1)[31:0], slot(1)[SW-1 -: 32]); end
        total++; if (slot(2) !== bc(32'hDEAD_BEEF)) begin bad++; $display("FAIL scalar_slot2 got lane0=%h lane63=%h want deadbeef", slot(2)[31:0], slot(2)[SW-1 -: 32]); end
        release_out();
        total++; if (issue_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL scalar_release got ready=%b valid=%b want 1/0", issue_ready, out_valid); end
    endtask

    task automatic test_vgpr_ooo();
        do_accept(12'h232, 30'h0, {32'h0, 32'h0000_55AA, 32'h0}, 32'h0);
        total++; if (out_valid !== 1'b0 || issue_ready !== 1'b0) begin bad++; $display("FAIL vgpr_collecting got valid=%b ready=%b want 0/0", out_valid, issue_ready); end
        beat(2'd2, vd2);
        step();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vgpr_early_valid got %b want 0", out_valid); end
        beat(2'd0, vd0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL vgpr_valid_latency got %b want 1", out_valid); end
        total++; if (slot(0) !== vd0) begin bad++; $display("FAIL vgpr_slot0 got lane0=%h lane63=%h want a0000000/a000003f", slot(0)[31:0], slot(0)[SW-1 -: 32]); end
        total++; if (slot(1) !== bc(32'h0000_55AA)) begin bad++; $display("FAIL vgpr_slot1 got lane0=%h want 000055aa", slot(1)[31:0]); end
        total++; if (slot(2) !== vd2) begin bad++; $display("FAIL vgpr_slot2 got lane0=%h lane63=%h want b0000000/b000003f", slot(2)[31:0], slot(2)[SW-1 -: 32]); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL vgpr_err got %b want 0", out_err); end
        release_out();
    endtask

    task automatic test_backpressure();
        do_accept(12'h000, 30'h0, 96'h0, 32'h1234_5678);
        issue_literal = 32'hFFFF_0000;
        sgpr_rd_data  = {3{32'hAAAA_AAAA}};
        for (int c = 0; c < 5; c++) begin
            total++; if (out_valid !== 1'b1 || issue_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ctl cycle %0d got valid=%b ready=%b want 1/0", c, out_valid, issue_ready); end
            total++; if (out_data !== {NS{bc(32'h1234_5678)}}) begin bad++; $display("FAIL bp_hold_data cycle %0d got lane0=%h want 12345678", c, out_data[31:0]); end
            step();
        end
        release_out();
        total++; if (issue_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", issue_ready, out_valid); end
    endtask

    task automatic test_flags();
        vcc_v  = 64'h0;
        exec_v = 64'hFFFF_FFFF_FFFF_FFFF;
        scc_v  = 1'b1;
        do_accept(12'hBA9, 30'h0, 96'h0, 32'h0);
        total++; if (out_data !== {bc(32'd1), bc(32'd0), bc(32'd1)}) begin bad++; $display("FAIL flags_a got s0=%h s1=%h s2=%h want 1/0/1", slot(0)[31:0], slot(1)[31:0], slot(2)[31:0]); end
        release_out();
        vcc_v  = 64'h0000_0001_0000_0000;
        exec_v = 64'h0;
        scc_v  = 1'b0;
        do_accept(12'hBA9, 30'h0, 96'h0, 32'h0);
        total++; if (out_data !== {bc(32'd0), bc(32'd1), bc(32'd0)}) begin bad++; $display("FAIL flags_b got s0=%h s1=%h s2=%h want 0/1/0", slot(0)[31:0], slot(1)[31:0], slot(2)[31:0]); end
        release_out();
    endtask

    task automatic test_halves();
        vcc_v  = 64'h1111_2222_3333_4444;
        exec_v = 64'h5555_6666_7777_8888;
        m0_v   = 32'hCAFE_F00D;
        do_accept(12'h546, 30'h0, 96'h0, 32'h0);
        total++; if (out_data !== {bc(32'h1111_2222), bc(32'h3333_4444), bc(32'hCAFE_F00D)}) begin bad++; $display("FAIL halves_vcc_m0 got s0=%h s1=%h s2=%h want cafef00d/33334444/11112222", slot(0)[31:0], slot(1)[31:0], slot(2)[31:0]); end
        release_out();
        do_accept(12'h871, {10'h0, 10'h0, 10'h155}, 96'h0, 32'h0);
        total++; if (out_data !== {bc(32'h5555_6666), bc(32'h7777_8888), bc(32'h0000_0155)}) begin bad++; $display("FAIL halves_exec_const got s0=%h s1=%h s2=%h want 00000155/77778888/55556666", slot(0)[31:0], slot(1)[31:0], slot(2)[31:0]); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL halves_err got %b want 0", out_err); end
        release_out();
    endtask

    task automatic test_illegal_stray();
        do_accept(12'h00C, 30'h0, 96'h0, 32'h0BAD_F00D);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL illegal_valid got %b want 1", out_valid); end
        total++; if (slot(0) !== '0) begin bad++; $display("FAIL illegal_slot0 got lane0=%h want 0", slot(0)[31:0]); end
        total++; if (slot(2) !== bc(32'h0BAD_F00D)) begin bad++; $display("FAIL illegal_slot2 got lane0=%h want 0badf00d", slot(2)[31:0]); end
        total++; if (out_err !== 1'b1) begin bad++; $display("FAIL illegal_err got %b want 1", out_err); end
        release_out();
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_accept(12'h232, 30'h0, {32'h0, 32'h0000_0077, 32'h0}, 32'h0);
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL stray_pre_err got %b want 0", out_err); end
        beat(2'd1, vjunk);
        total++; if (out_err !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL stray_beat got err=%b valid=%b want 1/0", out_err, out_valid); end
        beat(2'd0, vd0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stray_pending_kept got valid=%b want 0", out_valid); end
        beat(2'd2, vd2);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stray_complete got valid=%b want 1", out_valid); end
        total++; if (out_data !== {vd2, bc(32'h0000_0077), vd0}) begin bad++; $display("FAIL stray_data got s0=%h s1=%h s2=%h want a0000000/00000077/b0000000", slot(0)[31:0], slot(1)[31:0], slot(2)[31:0]); end
        release_out();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_accept(12'h232, 30'h0, {32'h0, 32'h0000_0099, 32'h0}, 32'h0);
        beat(2'd0, vd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || issue_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ctl got valid=%b ready=%b want 0/1", out_valid, issue_ready); end
        total++; if (out_data !== '0 || out_err !== 1'b0) begin bad++; $display("FAIL mid_reset_state got lane0=%h err=%b want 0/0", out_data[31:0], out_err); end
        beat(2'd2, vd2);
        total++; if (out_err !== 1'b1) begin bad++; $display("FAIL late_beat_err got %b want 1", out_err); end
        total++; if (out_valid !== 1'b0 || issue_ready !== 1'b1 || out_data !== '0) begin bad++; $display("FAIL late_beat_state got valid=%b ready=%b lane0=%h want 0/1/0", out_valid, issue_ready, out_data[31:0]); end
    endtask

    initial begin
        rst                = 1'b1;
        issue_valid        = 1'b0;
        issue_sel          = '0;
        issue_src_constant = '0;
        issue_literal      = '0;
        sgpr_rd_data       = '0;
        exec_v             = '0;
        vcc_v              = '0;
        m0_v               = '0;
        scc_v              = 1'b0;
        vgpr_rd_valid      = 1'b0;
        vgpr_rd_idx        = '0;
        vgpr_rd_data       = '0;
        out_ready          = 1'b0;
        for (int l = 0; l < NL; l++) begin
            vd0[l*LW +: LW]   = 32'hA000_0000 + 32'(l);
            vd2[l*LW +: LW]   = 32'hB000_0000 + 32'(l);
            vjunk[l*LW +: LW] = 32'hEEEE_0000 + 32'(l);
        end

        test_reset();
        test_scalar();
        test_vgpr_ooo();
        test_backpressure();
        test_flags();
        test_halves();
        test_illegal_stray();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Registered, parametrised successor to the single-source ALU operand mux.
- Collects up to NUM_SRC ALU operands per instruction. Each source is selected independently: literal, inline constant, SGPR, VCC/EXEC/M0 halves, VCCZ/EXECZ/SCC, or VGPR.
- Scalar sources are broadcast across NUM_LANES lanes. VGPR sources arrive later, in any order, from the VGPR read port.
- Presents the complete operand set to the ALU datapath with a valid/ready handshake.
- Sits between the issue/decode stage and the SIMD/SIMF ALU.

Parameters:
- NUM_LANES, 64, number of SIMD lanes.
- LANE_W, 32, bits per lane.
- NUM_SRC, 3, number of operand slots (1..4).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- issue_valid  input  1  instruction operand request valid.
- issue_ready  output  1  collector can accept a request.
- issue_sel  input  4*NUM_SRC  per-slot select code; slot i = bits [4i+3:4i].
- issue_src_constant  input  10*NUM_SRC  per-slot signed inline constant.
- issue_literal  input  32  literal constant, shared by all slots.
- sgpr_rd_data  input  32*NUM_SRC  per-slot SGPR value, valid in the issue cycle.
- exec_rd_exec_value  input  64  EXEC mask, valid in the issue cycle.
- exec_rd_vcc_value  input  64  VCC, valid in the issue cycle.
- exec_rd_m0_value  input  32  M0, valid in the issue cycle.
- exec_rd_scc_value  input  1  SCC, valid in the issue cycle.
- vgpr_rd_valid  input  1  VGPR return beat valid.
- vgpr_rd_idx  input  2  slot index the beat belongs to.
- vgpr_rd_data  input  LANE_W*NUM_LANES  VGPR lane data.
- out_valid  output  1  operand set complete.
- out_ready  input  1  ALU consumes the operand set.
- out_data  output  NUM_SRC*LANE_W*NUM_LANES  operand slots; slot i occupies bits [(i+1)*LANE_W*NUM_LANES-1 : i*LANE_W*NUM_LANES].
- out_err  output  1  sticky error flag.

Behaviour:
- Select codes, per slot, where "broadcast X" means X replicated to every lane:
  - 0000 broadcast literal.
  - 0001 broadcast 10-bit constant, sign-extended to LANE_W.
  - 0010 VGPR (deferred).
  - 0011 broadcast SGPR.
  - 0100 VCC[31:0]; 0101 VCC[63:32].
  - 0110 M0.
  - 0111 EXEC[31:0]; 1000 EXEC[63:32].
  - 1001 VCCZ, i.e. 1 iff VCC==0, zero-extended.
  - 1010 EXECZ, i.e. 1 iff EXEC==0, zero-extended.
  - 1011 SCC, zero-extended.
  - 11xx illegal: slot forced to all zeros and out_err set.
- States: IDLE, COLLECT, DONE.
  - issue_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
- Accept happens on issue_valid && issue_ready. On accept:
  - All non-VGPR slots are computed and registered in that cycle.
  - Scalar inputs are not sampled afterwards.
  - pending[NUM_SRC-1:0] is set to the slots whose code is 0010.
  - Slots at index >= NUM_SRC are ignored.
- IDLE -> DONE on accept with pending==0. out_valid is asserted the next cycle, i.e. 1-cycle latency.
- IDLE -> COLLECT on accept with pending!=0.
- COLLECT, on vgpr_rd_valid:
  - If pending[vgpr_rd_idx]: store vgpr_rd_data into that slot and clear the bit.
  - When the last pending bit clears: -> DONE the next cycle.
  - out_valid rises 1 cycle after the last beat.
- Beat for a non-pending slot, an idx >= NUM_SRC, or any beat in IDLE/DONE: data discarded, out_err set, state unchanged.
- DONE:
  - out_data is held stable while out_valid && !out_ready.
  - On out_ready -> IDLE.
  - The next accept is possible the cycle after.
- out_err is sticky until rst. It does not block operation.
- Reset (synchronous, any state including mid-COLLECT):
  - state IDLE, pending 0, out_valid 0, out_data 0, out_err 0.
  - issue_ready = 1 in the cycle after rst deasserts.
  - Partial operands are discarded.
- A vgpr_rd_valid beat in the same cycle as an accept is treated as a stray beat: discarded, out_err set.

Test Plan:
- Scalar only (NUM_SRC=3): accept with sel={0011,0001,0000}, sgpr slot0=0x1234, const slot1=10'h3FF, literal=0xDEADBEEF -> one cycle later:
  - out_valid=1.
  - Every lane: slot0=0x00001234, slot1=0xFFFFFFFF, slot2=0xDEADBEEF.
- Out-of-order VGPR: sel={0010,0011,0010}; beats idx2 then, 3 cycles later, idx0 -> out_valid exactly 1 cycle after the idx0 beat, with both VGPR slots correct.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data stable, issue_ready=0; out_ready=1 -> IDLE, issue_ready=1 next cycle.
- Flags: VCC=0, EXEC=0xFFFF_FFFF_FFFF_FFFF, SCC=1 with sel={1001,1010,1011} -> lanes {1,0,1}.
- Illegal/stray: sel slot0=1100 -> slot0 zeros, out_err=1. A beat for non-pending idx1 while in COLLECT -> data discarded, out_err=1, pending unchanged.
- Reset mid-COLLECT with one beat outstanding -> next cycle out_valid=0, out_data=0, issue_ready=1; a late beat arriving after reset sets out_err only.
